// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode map and FSM state type shared by the alu_mc slice.
package alu_mc_pkg;
  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_SKZ = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_STO = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/alu_mc_mul.sv
// alu_mc_mul: iterative shift-add multiplier, one multiplier bit per cycle.
module alu_mc_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] cnt;
  // product is the accumulator after the current iteration, so the caller can
  // commit it on the same edge as the final step
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = cnt == CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked accumulator ALU with single-cycle ops and iterative MUL.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry
);
  localparam int SW = $clog2(WIDTH);
  state_t state, state_next;
  logic accept, is_mul, mul_done, cy;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] res;
  logic [SW-1:0] n;
  logic [WIDTH:0] sum, dif, shl, shr;
  assign in_ready = state == IDLE && !reset;
  assign accept = in_valid && in_ready;
  assign is_mul = MUL_EN && opcode == OP_MUL;
  assign n = data[SW-1:0];
  assign sum = {1'b0, accum} + {1'b0, data};
  assign dif = {1'b0, accum} - {1'b0, data};
  // the extra bit on each shift catches the last bit shifted out
  assign shl = {1'b0, accum} << n;
  assign shr = {accum, 1'b0} >> n;
  always_comb begin
    res = accum;
    cy = 1'b0;
    case (opcode)
      OP_ADD: {cy, res} = sum;
      OP_AND: res = accum & data;
      OP_XOR: res = accum ^ data;
      OP_LDA: res = data;
      OP_SUB: {cy, res} = dif;
      OP_OR:  res = accum | data;
      OP_SHL: {cy, res} = shl;
      OP_SHR: {res, cy} = shr;
      default: ;
    endcase
  end
  always_comb
    state_next = state == IDLE ? (accept && is_mul ? BUSY : IDLE) : (mul_done ? IDLE : BUSY);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      alu_out   <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        alu_out   <= res;
        zero      <= res == '0;
        carry     <= cy;
        out_valid <= 1'b1;
      end else if (state == BUSY && mul_done) begin
        alu_out   <= product[WIDTH-1:0];
        zero      <= product[WIDTH-1:0] == '0;
        carry     <= |product[2*WIDTH-1:WIDTH];
        out_valid <= 1'b1;
      end
    end
  if (MUL_EN) begin : g_mul
    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
      .clk(clk),
      .reset(reset),
      .start(accept && is_mul),
      .a(accum),
      .b(data),
      .done(mul_done),
      .product(product)
    );
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign product = '0;
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc plus WIDTH=16 and MUL_EN=0 corners.
module tb_alu_mc;
  typedef struct {logic [7:0] r; bit c;} exp_t;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, out_valid, zero, carry;
  logic [3:0] opcode = 0;
  logic [7:0] accum = 0, data = 0, alu_out;
  logic v16 = 0, rdy16, ov16, z16, c16;
  logic [3:0] op16 = 0;
  logic [15:0] a16 = 0, d16 = 0, r16;
  logic v0 = 0, rdy0, ov0, z0, c0;
  logic [3:0] op0 = 0;
  logic [7:0] a0 = 0, d0 = 0, r0;
  int checks = 0, fails = 0;
  exp_t q[$];
  exp_t em;

  alu_mc #(.WIDTH(8), .MUL_EN(1)) dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .accum(accum), .data(data), .out_valid(out_valid), .alu_out(alu_out), .zero(zero), .carry(carry));
  alu_mc #(.WIDTH(16), .MUL_EN(1)) dut16 (.clk(clk), .reset(reset), .in_valid(v16), .in_ready(rdy16),
    .opcode(op16), .accum(a16), .data(d16), .out_valid(ov16), .alu_out(r16), .zero(z16), .carry(c16));
  alu_mc #(.WIDTH(8), .MUL_EN(0)) dut0 (.clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0),
    .opcode(op0), .accum(a0), .data(d0), .out_valid(ov0), .alu_out(r0), .zero(z0), .carry(c0));

  function automatic void model(input int w, input bit men, input int op, input longint a, input longint d,
                                output longint r, output bit c);
    longint m;
    int n;
    m = (longint'(1) << w) - 1;
    n = int'(d % w);
    r = a;
    c = 0;
    case (op)
      2: begin r = (a + d) & m; c = (a + d) > m; end
      3: r = a & d;
      4: r = a ^ d;
      5: r = d;
      8: begin r = (a - d) & m; c = a < d; end
      9: r = a | d;
      10: begin r = (a << n) & m; c = n != 0 && ((a >> (w - n)) & 1) != 0; end
      11: begin r = a >> n; c = n != 0 && ((a >> (n - 1)) & 1) != 0; end
      12: if (men) begin r = (a * d) & m; c = (a * d) > m; end
      default: ;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out_valid: got alu_out=%h with no pending op", alu_out);
      end else begin
        em = q.pop_front();
        chk("result{alu_out,zero,carry}", {22'd0, alu_out, zero, carry}, {22'd0, em.r, em.r == 8'd0, em.c});
      end
    end

  task automatic issue(input int op, input int a, input int d);
    longint r;
    bit c;
    int t = 0;
    @(negedge clk);
    in_valid = 1;
    opcode = op[3:0];
    accum = a[7:0];
    data = d[7:0];
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
    end else begin
      model(8, 1, op, a, d, r, c);
      q.push_back('{r[7:0], c});
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
    accum = 8'($urandom);
    data = 8'($urandom);
  endtask

  initial begin
    int cnt;
    longint r;
    bit c;
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    longint r;
    bit c;
    #1 reset = 1;
    #1;
    chk("reset_alu_out", alu_out, 0);
    chk("reset_zero", zero, 1);
    chk("reset_carry", carry, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    // basic ops then a mid-cycle reset over a held result
    issue(2, 'hF0, 'h20);
    idle();
    issue(7, 'h3C, 'h99);
    idle();
    issue(2, 'hF0, 'h20);
    idle();
    #2 reset = 1;
    #1;
    chk("async_reset_alu_out", alu_out, 0);
    chk("async_reset_flags", {zero, carry, out_valid}, 3'b100);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    // back-to-back single-cycle ops
    issue(8, 'h05, 'h05);
    issue(8, 'h03, 'h05);
    issue(4, 'hAA, 'h55);
    issue(5, 'h77, 'h00);
    idle();
    idle();
    // multiply latency and busy window
    issue(12, 'h0D, 'h0B);
    @(negedge clk);
    in_valid = 0;
    accum = 8'hFF;
    data = 8'hFF;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
      accum = 8'($urandom);
      data = 8'($urandom);
    end
    chk("mul_busy_cycles", cnt, 8);
    chk("mul_out_valid_with_ready", out_valid, 1);
    issue(12, 'h10, 'h10);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    in_valid = 1;
    opcode = 4'd2;
    @(negedge clk);
    in_valid = 0;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    idle();
    // shifts
    issue(10, 'h81, 'h01);
    issue(11, 'h81, 'h03);
    issue(10, 'h81, 'h09);
    issue(11, 'h81, 'h08);
    idle();
    // reset mid-multiply aborts without a result
    issue(12, 'h07, 'h09);
    idle();
    idle();
    idle();
    #1 reset = 1;
    q.delete();
    #1;
    chk("mul_abort_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 0;
    repeat (12) idle();
    issue(2, 'h11, 'h22);
    idle();
    // WIDTH=16 instance
    @(negedge clk);
    v16 = 1; op16 = 4'd2; a16 = 16'hFFFF; d16 = 16'h0001;
    @(negedge clk);
    v16 = 0;
    chk("w16_add", {ov16, r16, z16, c16}, {1'b1, 16'h0000, 1'b1, 1'b1});
    model(16, 1, 10, 'h0003, 'h001F, r, c);
    v16 = 1; op16 = 4'd10; a16 = 16'h0003; d16 = 16'h001F;
    @(negedge clk);
    v16 = 0;
    chk("w16_shl15", {ov16, r16, c16}, {1'b1, r[15:0], c});
    // MUL_EN=0 instance: MUL is a one-cycle pass
    v0 = 1; op0 = 4'd12; a0 = 8'h12; d0 = 8'h34;
    @(negedge clk);
    v0 = 0;
    chk("nomul_pass", {ov0, r0, z0, c0, rdy0}, {1'b1, 8'h12, 1'b0, 1'b0, 1'b1});
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int op, a, d;
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 3) == 0 ? (($urandom_range(0, 1) == 0) ? 0 : 255) : $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      issue(op, a, d);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    cnt = 0;
    while (q.size() != 0 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
